sort_frame_loader: RTL and testbench
====================================

// Module: sort_frame_loader
// PURPOSE
// - Upstream stage of the bitonic sorting network (comparison_size_x).
// - Gathers a serial stream of NETWORK_WIDTH samples into SIZE-lane frames and tags each lane with its arrival index.
// - Presents each complete frame, held stable, on the network's data_in/index_in buses.
// - Ping-pong banks: the next frame fills while the current frame is being sorted and consumed.
// PARAMETERS
// - SIZE       4   Lanes per frame. Power of 2, >=2. Must equal the sorter's SIZE.
// - PAD_VALUE  '0  Data placed in unfilled lanes on flush. Sorts as minimum for unsigned compare.
// - NETWORK_WIDTH, INDEX_WIDTH: global constants from parameters.svh, not module parameters.
//   INDEX_WIDTH >= $clog2(SIZE).
// PORTS
// - clk           in   1                         Single clock, rising edge.
// - rst           in   1                         Asynchronous, active-high reset.
// - sample_in     in   NETWORK_WIDTH             Input sample.
// - sample_valid  in   1                         sample_in is valid this cycle.
// - sample_ready  out  1                         Loader accepts; transfer = valid & ready.
// - flush         in   1                         Close a partial frame, padding remaining lanes.
// - data_out      out  [SIZE][NETWORK_WIDTH]     Frame to sorter data_in.
// - index_out     out  [SIZE][INDEX_WIDTH]       Lane k carries index k.
// - lanes_used    out  $clog2(SIZE)+1            Real (non-pad) samples in the presented frame.
// - ready         out  1                         Frame on data_out/index_out is valid and stable.
// - done          in   1                         Downstream has consumed the presented frame.
// BEHAVIOUR
// - Reset (async, rst=1):
//   - both banks empty, fill pointer 0, w_bank=0, r_bank=0;
//   - ready=0, sample_ready=1 (as soon as rst deasserts);
//   - data_out=0, index_out=0, lanes_used=0;
//   - reset mid-frame or mid-presentation discards all data, with no partial output.
// - Lane order: k-th accepted sample of a frame goes to lane k (data_out[k]); index_out[k]=k always, pad lanes included.
// - Fill:
//   - on transfer, write bank[w_bank].lane[ptr] and increment ptr;
//   - on the write to lane SIZE-1, mark bank[w_bank] full with lanes_used=SIZE, set ptr=0 and toggle w_bank.
// - Flush:
//   - sampled when ptr>0 or a transfer occurs this cycle;
//   - lanes ptr..SIZE-1 (after any same-cycle write) are set to PAD_VALUE;
//   - the bank is marked full with lanes_used = count written, then ptr=0 and w_bank toggles;
//   - flush with ptr==0 and no transfer is ignored.
//   - Same-cycle transfer into lane SIZE-1 plus flush = a normal full frame with no padding.
// - sample_ready = !full[w_bank]; combinational from registered state only, not from sample_valid.
//   - Both banks full -> sample_ready=0 and flush is ignored.
// - Present:
//   - ready = full[r_bank], registered;
//   - data_out, index_out and lanes_used are muxed from bank[r_bank];
//   - when ready=0, outputs hold their last values (0 after reset).
// - Latency: full frame completed at edge N -> ready=1 after edge N, provided bank[r_bank] was empty.
// - Consume:
//   - done while ready=1 clears full[r_bank] and toggles r_bank at the same edge;
//   - if the other bank is full, ready stays 1 with the new frame, giving back-to-back frames;
//   - done while ready=0 is ignored.
// - Simultaneous completion of bank X and done on bank Y: both take effect at the same edge.
// - Sustained throughput: 1 sample/cycle when done is returned within SIZE cycles of ready.
// - data_out is guaranteed stable from ready rising until the done edge, for a combinational or pipelined sorter.
// STRUCTURE
// - parameters.svh supplies NETWORK_WIDTH and INDEX_WIDTH.
// - Add to parameters.svh: the lane-count width macro and a PAD_VALUE default.
// - One sub-module, sort_frame_bank: a single SIZE-lane register bank with write_lane, pad_from and clear.
//   Instantiated twice. Ping-pong control and muxing live in the top level.
// TESTING
// - Reset, then 4 samples 7,3,9,1 back-to-back:
//   ready=1 the cycle after the 4th transfer; data_out=[7,3,9,1]; index_out=[0,1,2,3]; lanes_used=4.
// - Hold done=0 and stream 8 samples:
//   - the 2nd frame fills;
//   - sample_ready drops after the 8th transfer, and the 9th sample stalls;
//   - done -> 2nd frame presented next cycle, and sample_ready=1.
// - 2 samples 5,6, then flush:
//   data_out=[5,6,0,0]; lanes_used=2.
//   Flush on an empty fill is ignored, with no ready pulse.
// - Transfer into lane 3 with flush in the same cycle:
//   lanes_used=4, no pad lanes written, next frame starts at lane 0.
// - Assert rst mid-fill (ptr=2) and mid-present:
//   ready=0, data_out=0 immediately; the first post-reset sample lands in lane 0.
// - Random valid/done back-pressure over 1000 frames:
//   a scoreboard confirms order, indices and padding; no frame is lost or duplicated.

Source files
------------

// File: rtl/sort_frame_loader_pkg.sv
// Shared constants and types for the sort frame loader.
//   NETWORK_WIDTH / INDEX_WIDTH : global sample and lane-index widths of the sorter.
//   PAD_DEFAULT                 : default pad data (sorts as the unsigned minimum).
//   lane_count_width()          : width of a 0..SIZE lane count.
//   bank_sel_t                  : ping-pong bank selector.
package sort_frame_loader_pkg;

  localparam int unsigned NETWORK_WIDTH = 16;
  localparam int unsigned INDEX_WIDTH   = 4;

  localparam logic [NETWORK_WIDTH-1:0] PAD_DEFAULT = '0;

  function automatic int unsigned lane_count_width(input int unsigned size);
    return $clog2(size) + 1;
  endfunction

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_sel_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/sort_frame_bank.sv
// One SIZE-lane frame register bank of the ping-pong loader.
//   write_en/write_lane/write_data : store one sample into a lane.
//   pad_en/pad_from                : fill lanes pad_from..SIZE-1 with PAD_VALUE.
//   close/close_count              : mark the bank full with close_count real lanes.
//   clear                          : release the bank after the frame was consumed.
//   lanes_nxt/full_nxt/lanes_used_nxt : next-state view, so the top level can
//                                    present a frame on the same edge it completes.
//   full                           : registered full flag.
module sort_frame_bank
  import sort_frame_loader_pkg::*;
#(
  parameter int unsigned               SIZE      = 4,
  parameter logic [NETWORK_WIDTH-1:0]  PAD_VALUE = PAD_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   write_en,
  input  logic [$clog2(SIZE)-1:0]                write_lane,
  input  logic [NETWORK_WIDTH-1:0]               write_data,
  input  logic                                   pad_en,
  input  logic [$clog2(SIZE):0]                  pad_from,
  input  logic                                   close,
  input  logic [$clog2(SIZE):0]                  close_count,
  input  logic                                   clear,
  output logic [SIZE-1:0][NETWORK_WIDTH-1:0]     lanes_nxt,
  output logic                                   full_nxt,
  output logic [$clog2(SIZE):0]                  lanes_used_nxt,
  output logic                                   full
);

  localparam int unsigned PW = $clog2(SIZE);
  localparam int unsigned LW = PW + 1;

  logic [SIZE-1:0][NETWORK_WIDTH-1:0] lanes;
  logic [LW-1:0]                      lanes_used;

  // pad_from is the count after any same-cycle write, so the written lane is
  // never inside the padded range.
  always_comb begin
    lanes_nxt      = lanes;
    full_nxt       = full;
    lanes_used_nxt = lanes_used;
    for (int unsigned k = 0; k < SIZE; k++) begin
      if (write_en && (write_lane == PW'(k))) begin
        lanes_nxt[k] = write_data;
      end
      if (pad_en && (LW'(k) >= pad_from)) begin
        lanes_nxt[k] = PAD_VALUE;
      end
    end
    if (close) begin
      full_nxt       = 1'b1;
      lanes_used_nxt = close_count;
    end
    if (clear) begin
      full_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes      <= '0;
      full       <= 1'b0;
      lanes_used <= '0;
    end else begin
      lanes      <= lanes_nxt;
      full       <= full_nxt;
      lanes_used <= lanes_used_nxt;
    end
  end

endmodule

// File: rtl/sort_frame_loader.sv
// Serial-to-frame loader in front of the bitonic sorting network.
//   clk, rst                 : clock, asynchronous active-high reset.
//   sample_in/sample_valid   : input stream; sample_ready = loader can accept.
//   flush                    : close a partial frame, padding the remaining lanes.
//   data_out/index_out       : presented frame and lane indices (lane k -> k).
//   lanes_used               : real samples in the presented frame.
//   ready                    : presented frame is valid and stable.
//   done                     : downstream consumed the presented frame.
// Two banks ping-pong: one fills while the other is presented.
module sort_frame_loader
  import sort_frame_loader_pkg::*;
#(
  parameter int unsigned               SIZE      = 4,
  parameter logic [NETWORK_WIDTH-1:0]  PAD_VALUE = PAD_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NETWORK_WIDTH-1:0]             sample_in,
  input  logic                                 sample_valid,
  output logic                                 sample_ready,
  input  logic                                 flush,
  output logic [SIZE-1:0][NETWORK_WIDTH-1:0]   data_out,
  output logic [SIZE-1:0][INDEX_WIDTH-1:0]     index_out,
  output logic [$clog2(SIZE):0]                lanes_used,
  output logic                                 ready,
  input  logic                                 done
);

  localparam int unsigned PW = $clog2(SIZE);
  localparam int unsigned LW = lane_count_width(SIZE);

  logic [PW-1:0] ptr;
  bank_sel_t     w_bank;
  bank_sel_t     r_bank;

  logic [1:0] w_sel, r_sel, r_nxt_sel;
  logic [1:0] bank_full, bank_full_nxt;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0] lanes_nxt [2];
  logic [LW-1:0]                      used_nxt  [2];

  logic          transfer, last, flush_eff, close, pad_en, consume, present_nxt;
  logic [LW-1:0] count_after, close_count;
  logic [SIZE-1:0][INDEX_WIDTH-1:0] lane_ids;

  always_comb begin
    w_sel        = (w_bank == BANK_1) ? 2'b10 : 2'b01;
    r_sel        = (r_bank == BANK_1) ? 2'b10 : 2'b01;
    sample_ready = ~|(bank_full & w_sel);
    transfer     = sample_valid & sample_ready;
    last         = transfer && (ptr == PW'(SIZE - 1));
    count_after  = {1'b0, ptr} + LW'(transfer);
    // A flush needs something in the frame (already or this cycle) and a
    // writable bank; a flush coinciding with the last lane is a plain full frame.
    flush_eff    = flush && sample_ready && ((ptr != '0) || transfer);
    close        = last | flush_eff;
    close_count  = last ? LW'(SIZE) : count_after;
    pad_en       = flush_eff & ~last;
    consume      = ready & done;
    r_nxt_sel    = consume ? {r_sel[0], r_sel[1]} : r_sel;
    present_nxt  = |(bank_full_nxt & r_nxt_sel);
    for (int unsigned k = 0; k < SIZE; k++) begin
      lane_ids[k] = INDEX_WIDTH'(k);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sort_frame_bank #(
      .SIZE      (SIZE),
      .PAD_VALUE (PAD_VALUE)
    ) u_bank (
      .clk            (clk),
      .rst            (rst),
      .write_en       (transfer & w_sel[b]),
      .write_lane     (ptr),
      .write_data     (sample_in),
      .pad_en         (pad_en & w_sel[b]),
      .pad_from       (count_after),
      .close          (close & w_sel[b]),
      .close_count    (close_count),
      .clear          (consume & r_sel[b]),
      .lanes_nxt      (lanes_nxt[b]),
      .full_nxt       (bank_full_nxt[b]),
      .lanes_used_nxt (used_nxt[b]),
      .full           (bank_full[b])
    );
  end

  // Outputs are loaded from the banks' next state so a frame completing at an
  // edge is presented right after it; otherwise they hold their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      w_bank     <= BANK_0;
      r_bank     <= BANK_0;
      ready      <= 1'b0;
      data_out   <= '0;
      index_out  <= '0;
      lanes_used <= '0;
    end else begin
      if (close) begin
        ptr    <= '0;
        w_bank <= other_bank(w_bank);
      end else if (transfer) begin
        ptr <= ptr + PW'(1);
      end
      if (consume) begin
        r_bank <= other_bank(r_bank);
      end
      ready <= present_nxt;
      if (present_nxt) begin
        data_out   <= lanes_nxt[r_nxt_sel[1]];
        lanes_used <= used_nxt[r_nxt_sel[1]];
        index_out  <= lane_ids;
      end
    end
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;
  import sort_frame_loader_pkg::*;

  localparam int unsigned SZ = 4;
  localparam int unsigned NW = NETWORK_WIDTH;

  typedef logic [SZ-1:0][NW-1:0] lanes_t;
  typedef struct {
    lanes_t      data;
    int unsigned used;
  } frame_t;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NW-1:0]                  sample_in;
  logic                           sample_valid;
  logic                           sample_ready;
  logic                           flush;
  logic [SZ-1:0][NW-1:0]          data_out;
  logic [SZ-1:0][INDEX_WIDTH-1:0] index_out;
  logic [$clog2(SZ):0]            lanes_used;
  logic                           ready;
  logic                           done;

  sort_frame_loader #(.SIZE(SZ), .PAD_VALUE(PAD_DEFAULT)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .flush        (flush),
    .data_out     (data_out),
    .index_out    (index_out),
    .lanes_used   (lanes_used),
    .ready        (ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queues of samples and frames -------
  frame_t        frames[$];    // completed, not yet consumed (head = presented)
  logic [NW-1:0] part[$];      // samples of the frame being gathered
  int unsigned   produced = 0;
  logic          exp_ready;
  lanes_t        exp_data;
  logic [15:0]   exp_index;
  int unsigned   exp_used;
  int unsigned   m_pend;
  bit            m_xfer, m_flush;
  frame_t        m_frame;

  function automatic void model_reset();
    frames.delete();
    part.delete();
    exp_ready = 1'b0;
    exp_data  = '0;
    exp_index = '0;
    exp_used  = 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_pend  = frames.size();
      m_xfer  = sample_valid && (m_pend < 2);
      m_flush = flush && (m_pend < 2) && ((part.size() > 0) || m_xfer);
      if (done && (m_pend > 0)) void'(frames.pop_front());
      if (m_xfer) part.push_back(sample_in);
      if ((part.size() == SZ) || m_flush) begin
        m_frame.data = '0;
        for (int k = 0; k < part.size(); k++) m_frame.data[k] = part[k];
        m_frame.used = part.size();
        frames.push_back(m_frame);
        part.delete();
        produced++;
      end
      if (frames.size() > 0) begin
        exp_ready = 1'b1;
        exp_data  = frames[0].data;
        exp_used  = frames[0].used;
        exp_index = 16'h3210;
      end else begin
        exp_ready = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare against the model -------------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("sample_ready", sample_ready, (frames.size() < 2));
      check("ready",        ready,        exp_ready);
      check("data_out",     data_out,     exp_data);
      check("index_out",    index_out,    exp_index);
      check("lanes_used",   lanes_used,   exp_used);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic drive(input bit v, input logic [NW-1:0] d, input bit f, input bit dn);
    sample_valid = v;
    sample_in    = d;
    flush        = f;
    done         = dn;
    @(negedge clk);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    sample_in    = '0;
    flush        = 1'b0;
    done         = 1'b0;
    rst          = 1'b1;
    model_reset();
    #2;
    check("rst_ready",        ready,        0);
    check("rst_data_out",     data_out,     0);
    check("rst_index_out",    index_out,    0);
    check("rst_lanes_used",   lanes_used,   0);
    check("rst_sample_ready", sample_ready, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int unsigned cyc;
  int unsigned start_frames;

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    flush        = 1'b0;
    done         = 1'b0;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    // first frame 7,3,9,1
    drive(1, 7, 0, 0);
    drive(1, 3, 0, 0);
    drive(1, 9, 0, 0);
    check("ready_before_4th", ready, 0);
    drive(1, 1, 0, 0);
    check("f1_ready", ready, 1);
    check("f1_data",  data_out,  {16'd1, 16'd9, 16'd3, 16'd7});
    check("f1_index", index_out, {4'd3, 4'd2, 4'd1, 4'd0});
    check("f1_used",  lanes_used, 4);

    // second frame fills while the first is held; then stall
    drive(1, 10, 0, 0);
    drive(1, 11, 0, 0);
    drive(1, 12, 0, 0);
    drive(1, 13, 0, 0);
    check("both_full_sready", sample_ready, 0);
    drive(1, 14, 0, 0);
    drive(1, 14, 0, 0);
    check("stall_data", data_out, {16'd1, 16'd9, 16'd3, 16'd7});
    drive(1, 14, 0, 1);
    check("f2_ready",  ready, 1);
    check("f2_data",   data_out, {16'd13, 16'd12, 16'd11, 16'd10});
    check("f2_sready", sample_ready, 1);
    drive(0, 0, 0, 1);
    check("drained_ready", ready, 0);
    check("hold_data", data_out, {16'd13, 16'd12, 16'd11, 16'd10});

    // partial frame with flush, then a flush on an empty fill
    drive(1, 5, 0, 0);
    drive(1, 6, 0, 0);
    drive(0, 0, 1, 0);
    check("flush_data", data_out, {16'd0, 16'd0, 16'd6, 16'd5});
    check("flush_used", lanes_used, 2);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    check("empty_flush_ready0", ready, 0);
    drive(0, 0, 0, 0);
    check("empty_flush_ready1", ready, 0);

    // transfer into the last lane together with flush
    drive(1, 21, 0, 0);
    drive(1, 22, 0, 0);
    drive(1, 23, 0, 0);
    drive(1, 24, 1, 0);
    check("lastflush_data", data_out, {16'd24, 16'd23, 16'd22, 16'd21});
    check("lastflush_used", lanes_used, 4);
    drive(0, 0, 0, 1);
    drive(1, 25, 0, 0);
    drive(0, 0, 1, 0);
    check("next_lane0_data", data_out, {16'd0, 16'd0, 16'd0, 16'd25});
    check("next_lane0_used", lanes_used, 1);
    drive(0, 0, 0, 1);

    // reset mid-fill and mid-presentation
    drive(1, 31, 0, 0);
    drive(1, 32, 0, 0);
    do_reset();
    drive(1, 41, 0, 0);
    drive(1, 42, 0, 0);
    drive(1, 43, 0, 0);
    drive(1, 44, 0, 0);
    check("pre_rst_ready", ready, 1);
    do_reset();
    drive(1, 51, 0, 0);
    drive(1, 52, 0, 0);
    drive(1, 53, 0, 0);
    drive(1, 54, 0, 0);
    check("post_rst_data", data_out, {16'd54, 16'd53, 16'd52, 16'd51});
    drive(0, 0, 0, 1);

    // random back-pressure
    start_frames = produced;
    cyc = 0;
    while ((produced - start_frames < 1000) && (cyc < 40000)) begin
      drive(($urandom_range(0, 3) != 0), NW'($urandom_range(1, 65535)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
      cyc++;
    end
    check("random_frames_completed", (produced - start_frames >= 1000), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
